pipe_reg_stage: RTL and testbench

Parametrised pipeline register stage with valid/ready handshake, optional skid slot and synchronous flush. Next generation of the fixed 8-bit enable register: arbitrary width, backpressure instead of a raw enable, and a registered `in_ready` when `SKID=1`. Sits between any two pipeline stages of the datapath.

---
 rtl/pipe_reg_stage_pkg.sv | 12 +
 rtl/pipe_reg_stage_reg_nbit.sv | 21 ++
 rtl/pipe_reg_stage.sv | 110 +++++++++++
 tb/tb_pipe_reg_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_stage_pkg.sv
// Shared definitions for valid/ready handshake pipeline stages.
package pipe_reg_stage_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_reg_stage_reg_nbit.sv
// Synchronous-reset enable register used as a data slot of the stage.
module reg_nbit #(
    parameter int unsigned          WIDTH       = 8,
    parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_reg_stage.sv
// Pipeline register stage with valid/ready handshake, optional skid slot and flush.
module pipe_reg_stage
    import pipe_reg_stage_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter bit               SKID        = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occ
);

    state_e           state_q;
    state_e           state_nxt;
    logic             run_q;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;

    // With a skid slot, in_ready comes only from flops so out_ready never reaches it.
    assign in_ready = run_q & (SKID ? (state_q != ST_TWO) : (!out_valid | out_ready));
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            out_valid <= 1'b0;
            occ       <= '0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            out_valid <= (state_nxt != ST_EMPTY);
            occ       <= OCC_W'(state_nxt);
            run_q     <= 1'b1;
        end
    end

    // Flush discards everything, including any handshake in the same cycle.
    always_comb begin
        state_nxt = state_q;
        main_en   = 1'b0;
        skid_en   = 1'b0;
        main_d    = in_data;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_nxt = ST_ONE;
                        main_en   = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_en = 1'b1;
                    end else if (in_fire) begin
                        state_nxt = ST_TWO;
                        skid_en   = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        state_nxt = ST_ONE;
                        main_en   = 1'b1;
                        main_d    = skid_q;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    reg_nbit #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (out_data)
    );

    generate
        if (SKID) begin : g_skid
            reg_nbit #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
                .clk (clk),
                .rst (rst),
                .en  (skid_en),
                .d   (in_data),
                .q   (skid_q)
            );
        end else begin : g_noskid
            assign skid_q = RESET_VALUE;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_reg_stage.sv
// Directed and scoreboarded checks of pipe_reg_stage in both SKID modes.
module tb_pipe_reg_stage;
    logic       clk = 1'b0;
    logic       rst, flush;
    logic       iv1, ir1, ov1, or1;
    logic [7:0] id1, od1;
    logic [1:0] occ1;
    logic       iv0, ir0, ov0, or0;
    logic [7:0] id0, od0;
    logic [1:0] occ0;
    int         nchecks = 0;
    int         nfail   = 0;

    always #5 clk = ~clk;

    pipe_reg_stage #(.WIDTH(8), .SKID(1'b1), .RESET_VALUE(8'h00)) u1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv1), .in_ready(ir1), .in_data(id1),
        .out_valid(ov1), .out_ready(or1), .out_data(od1), .occ(occ1));

    pipe_reg_stage #(.WIDTH(8), .SKID(1'b0), .RESET_VALUE(8'h00)) u0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(iv0), .in_ready(ir0), .in_data(id0),
        .out_valid(ov0), .out_ready(or0), .out_data(od0), .occ(occ0));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0;
        iv1 = 1'b1; id1 = 8'hAA; or1 = 1'b0;
        iv0 = 1'b1; id0 = 8'hAA; or0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nchecks++; if (ov1 !== 1'b0) begin nfail++; $display("FAIL reset_ov1 got=%b exp=0", ov1); end
        nchecks++; if (occ1 !== 2'd0) begin nfail++; $display("FAIL reset_occ1 got=%0d exp=0", occ1); end
        nchecks++; if (od1 !== 8'h00) begin nfail++; $display("FAIL reset_od1 got=%h exp=00", od1); end
        nchecks++; if (ir1 !== 1'b0) begin nfail++; $display("FAIL reset_ir1_held got=%b exp=0", ir1); end
        nchecks++; if (ir0 !== 1'b0) begin nfail++; $display("FAIL reset_ir0_held got=%b exp=0", ir0); end
        nchecks++; if (ov0 !== 1'b0 || occ0 !== 2'd0 || od0 !== 8'h00) begin
            nfail++; $display("FAIL reset_u0 got=%b/%0d/%h exp=0/0/00", ov0, occ0, od0); end
        rst = 1'b0; iv1 = 1'b0; iv0 = 1'b0;
        tick();
        nchecks++; if (ir1 !== 1'b1) begin nfail++; $display("FAIL reset_ir1_release got=%b exp=1", ir1); end
        nchecks++; if (ir0 !== 1'b1) begin nfail++; $display("FAIL reset_ir0_release got=%b exp=1", ir0); end
        nchecks++; if (ov1 !== 1'b0) begin nfail++; $display("FAIL reset_ov1_release got=%b exp=0", ov1); end
    endtask

    task automatic test_stream();
        or1 = 1'b1; or0 = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            iv1 = 1'b1; id1 = 8'(i);
            iv0 = 1'b1; id0 = 8'(i);
            #1;
            nchecks++; if (ir1 !== 1'b1 || ir0 !== 1'b1) begin
                nfail++; $display("FAIL stream_ready i=%0d got=%b%b exp=11", i, ir1, ir0); end
            tick();
            nchecks++; if (ov1 !== 1'b1 || od1 !== 8'(i)) begin
                nfail++; $display("FAIL stream_u1 i=%0d got=%b/%h exp=1/%h", i, ov1, od1, 8'(i)); end
            nchecks++; if (ov0 !== 1'b1 || od0 !== 8'(i)) begin
                nfail++; $display("FAIL stream_u0 i=%0d got=%b/%h exp=1/%h", i, ov0, od0, 8'(i)); end
        end
        iv1 = 1'b0; iv0 = 1'b0;
        tick();
        nchecks++; if (ov1 !== 1'b0 || ov0 !== 1'b0) begin
            nfail++; $display("FAIL stream_drain got=%b%b exp=00", ov1, ov0); end
    endtask

    task automatic test_backpressure();
        or1 = 1'b0; iv1 = 1'b1; id1 = 8'h11;
        tick();
        nchecks++; if (occ1 !== 2'd1 || od1 !== 8'h11 || ir1 !== 1'b1) begin
            nfail++; $display("FAIL bp_first got=%0d/%h/%b exp=1/11/1", occ1, od1, ir1); end
        id1 = 8'h22;
        tick();
        nchecks++; if (occ1 !== 2'd2 || ir1 !== 1'b0 || od1 !== 8'h11) begin
            nfail++; $display("FAIL bp_full got=%0d/%b/%h exp=2/0/11", occ1, ir1, od1); end
        iv1 = 1'b0;
        tick();
        nchecks++; if (occ1 !== 2'd2 || od1 !== 8'h11 || ov1 !== 1'b1) begin
            nfail++; $display("FAIL bp_stable got=%0d/%h/%b exp=2/11/1", occ1, od1, ov1); end
        or1 = 1'b1;
        #1;
        nchecks++; if (ir1 !== 1'b0) begin nfail++; $display("FAIL bp_no_comb_ready got=%b exp=0", ir1); end
        tick();
        nchecks++; if (od1 !== 8'h22 || occ1 !== 2'd1 || ir1 !== 1'b1) begin
            nfail++; $display("FAIL bp_pop1 got=%h/%0d/%b exp=22/1/1", od1, occ1, ir1); end
        tick();
        nchecks++; if (ov1 !== 1'b0 || occ1 !== 2'd0) begin
            nfail++; $display("FAIL bp_pop2 got=%b/%0d exp=0/0", ov1, occ1); end
    endtask

    task automatic test_simultaneous();
        or1 = 1'b0; iv1 = 1'b1; id1 = 8'h33;
        tick();
        nchecks++; if (od1 !== 8'h33 || occ1 !== 2'd1) begin
            nfail++; $display("FAIL sim_hold got=%h/%0d exp=33/1", od1, occ1); end
        id1 = 8'h44; or1 = 1'b1;
        tick();
        nchecks++; if (od1 !== 8'h44 || occ1 !== 2'd1 || ov1 !== 1'b1) begin
            nfail++; $display("FAIL sim_swap got=%h/%0d/%b exp=44/1/1", od1, occ1, ov1); end
        iv1 = 1'b0;
        tick();
        nchecks++; if (occ1 !== 2'd0) begin nfail++; $display("FAIL sim_drain got=%0d exp=0", occ1); end
    endtask

    task automatic test_flush();
        or1 = 1'b0; iv1 = 1'b1; id1 = 8'h66;
        tick();
        id1 = 8'h77;
        tick();
        nchecks++; if (occ1 !== 2'd2) begin nfail++; $display("FAIL flush_fill got=%0d exp=2", occ1); end
        id1 = 8'h55; flush = 1'b1; or1 = 1'b1;
        tick();
        nchecks++; if (occ1 !== 2'd0 || ov1 !== 1'b0) begin
            nfail++; $display("FAIL flush_two got=%0d/%b exp=0/0", occ1, ov1); end
        nchecks++; if (od1 !== 8'h66) begin nfail++; $display("FAIL flush_keep_data got=%h exp=66", od1); end
        flush = 1'b0; id1 = 8'h88;
        tick();
        nchecks++; if (occ1 !== 2'd1 || od1 !== 8'h88) begin
            nfail++; $display("FAIL flush_refill got=%0d/%h exp=1/88", occ1, od1); end
        or1 = 1'b0; id1 = 8'h55; flush = 1'b1;
        #1;
        nchecks++; if (ir1 !== 1'b1) begin nfail++; $display("FAIL flush_one_ready got=%b exp=1", ir1); end
        tick();
        nchecks++; if (occ1 !== 2'd0 || ov1 !== 1'b0) begin
            nfail++; $display("FAIL flush_one got=%0d/%b exp=0/0", occ1, ov1); end
        flush = 1'b0; iv1 = 1'b0; or1 = 1'b1;
        tick();
        nchecks++; if (ov1 !== 1'b0) begin nfail++; $display("FAIL flush_no_55 got=%b/%h exp=0", ov1, od1); end
    endtask

    task automatic test_random();
        logic [7:0] q1[$];
        logic [7:0] q0[$];
        logic       ir_a;
        for (int c = 0; c < 10000; c++) begin
            iv1 = ($urandom_range(0, 3) != 0); id1 = 8'($urandom);
            or1 = ($urandom_range(0, 1) != 0);
            iv0 = ($urandom_range(0, 3) != 0); id0 = 8'($urandom);
            or0 = ($urandom_range(0, 1) != 0);
            #1;
            nchecks++; if (occ1 !== 2'(q1.size())) begin
                nfail++; $display("FAIL rnd_occ1 c=%0d got=%0d exp=%0d", c, occ1, q1.size()); end
            nchecks++; if (occ0 !== 2'(q0.size())) begin
                nfail++; $display("FAIL rnd_occ0 c=%0d got=%0d exp=%0d", c, occ0, q0.size()); end
            nchecks++; if (ir1 !== (q1.size() < 2)) begin
                nfail++; $display("FAIL rnd_ir1 c=%0d got=%b exp=%b", c, ir1, q1.size() < 2); end
            nchecks++; if (ir0 !== (q0.size() == 0 || or0)) begin
                nfail++; $display("FAIL rnd_ir0 c=%0d got=%b exp=%b", c, ir0, q0.size() == 0 || or0); end
            ir_a = ir1;
            or1 = ~or1;
            #1;
            nchecks++; if (ir1 !== ir_a) begin
                nfail++; $display("FAIL rnd_ir1_comb c=%0d got=%b exp=%b", c, ir1, ir_a); end
            or1 = ~or1;
            #1;
            if (ov1 && or1) begin
                nchecks++;
                if (q1.size() == 0) begin nfail++; $display("FAIL rnd_u1_extra c=%0d got=%h exp=none", c, od1); end
                else begin
                    if (od1 !== q1[0]) begin nfail++; $display("FAIL rnd_u1_data c=%0d got=%h exp=%h", c, od1, q1[0]); end
                    void'(q1.pop_front());
                end
            end
            if (ov0 && or0) begin
                nchecks++;
                if (q0.size() == 0) begin nfail++; $display("FAIL rnd_u0_extra c=%0d got=%h exp=none", c, od0); end
                else begin
                    if (od0 !== q0[0]) begin nfail++; $display("FAIL rnd_u0_data c=%0d got=%h exp=%h", c, od0, q0[0]); end
                    void'(q0.pop_front());
                end
            end
            if (iv1 && ir1) q1.push_back(id1);
            if (iv0 && ir0) q0.push_back(id0);
            tick();
        end
        iv1 = 1'b0; iv0 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
